// File: rtl/moving_average_ctrl.sv
// moving_average_ctrl: sequences 1-cycle ADC strobes into the level req/ack
// handshake of one movingAverage filter, handling width changes and priming.
//
// Ports:
//   clk, rst          clock, synchronous active-high reset
//   iAdcData/Valid    ADC sample + 1-cycle strobe
//   iWidthReq/Load    requested filter width + 1-cycle load strobe
//   oFiltData         sample to filter iDataIn
//   oFiltSampleReady  level request to filter
//   oFiltWidth        filter width (0 while flushing)
//   iFiltData/Ready   filter result + level ack
//   oData/oDataValid  filtered result + 1-cycle strobe
//   oPrimed           window holds only fresh samples
//   oOverrun          sticky: a sample was dropped
//   oTimeout          sticky: filter never acked
module moving_average_ctrl #(
  parameter int DATA_W      = 12,
  parameter int MAX_WIDTH   = 2048,
  parameter int FLUSH_CYC   = 4,
  parameter int TIMEOUT_CYC = 8191
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [DATA_W-1:0] iAdcData,
  input  logic              iAdcValid,
  input  logic [11:0]       iWidthReq,
  input  logic              iWidthLoad,
  output logic [DATA_W-1:0] oFiltData,
  output logic              oFiltSampleReady,
  output logic [11:0]       oFiltWidth,
  input  logic [DATA_W-1:0] iFiltData,
  input  logic              iFiltReady,
  output logic [DATA_W-1:0] oData,
  output logic              oDataValid,
  output logic              oPrimed,
  output logic              oOverrun,
  output logic              oTimeout
);

  localparam int FC_W = $clog2(FLUSH_CYC + 1);
  localparam int TC_W = $clog2(TIMEOUT_CYC + 1);
  localparam logic [11:0]     MAX_W      = 12'(MAX_WIDTH);
  localparam logic [FC_W-1:0] FLUSH_LAST = FC_W'(FLUSH_CYC - 1);
  localparam logic [TC_W-1:0] TO_LAST    = TC_W'(TIMEOUT_CYC - 1);

  typedef enum logic [2:0] {
    S_FLUSH,
    S_IDLE,
    S_REQ,
    S_WAIT_ACK,
    S_WAIT_LOW
  } state_t;

  state_t            state_q, state_d;
  logic [FC_W-1:0]   flush_cnt_q, flush_cnt_d;
  logic [TC_W-1:0]   to_cnt_q, to_cnt_d;
  logic [11:0]       active_w_q, active_w_d;
  logic [11:0]       pend_w_q, pend_w_d;
  logic              pend_vld_q, pend_vld_d;
  logic [DATA_W-1:0] hold_q, hold_d;
  logic              hold_vld_q, hold_vld_d;
  logic [11:0]       prime_cnt_q, prime_cnt_d;
  logic              primed_q, primed_d;
  logic [DATA_W-1:0] filt_data_q, filt_data_d;
  logic              filt_req_q, filt_req_d;
  logic [11:0]       filt_width_q, filt_width_d;
  logic [DATA_W-1:0] data_q, data_d;
  logic              data_vld_q, data_vld_d;
  logic              overrun_q, overrun_d;
  logic              timeout_q, timeout_d;

  logic wpend;
  logic take_hold;
  logic primed_now;

  function automatic logic [11:0] clamp_w(input logic [11:0] w);
    return (w > MAX_W) ? MAX_W : w;
  endfunction

  always_comb begin
    state_d      = state_q;
    flush_cnt_d  = flush_cnt_q;
    to_cnt_d     = to_cnt_q;
    active_w_d   = active_w_q;
    pend_w_d     = pend_w_q;
    pend_vld_d   = pend_vld_q;
    hold_d       = hold_q;
    hold_vld_d   = hold_vld_q;
    prime_cnt_d  = prime_cnt_q;
    filt_data_d  = filt_data_q;
    filt_req_d   = filt_req_q;
    filt_width_d = filt_width_q;
    data_d       = data_q;
    data_vld_d   = 1'b0;
    overrun_d    = overrun_q;
    timeout_d    = timeout_q;

    wpend      = iWidthLoad | pend_vld_q;
    primed_now = (prime_cnt_q >= active_w_q) ||
                 (active_w_q <= 12'd1);
    // In IDLE a sample only parks in the hold
    // register when a width change wins the cycle.
    take_hold  = iAdcValid &&
                 ((state_q != S_IDLE) || wpend);

    if (iWidthLoad && (state_q != S_IDLE)) begin
      pend_w_d   = clamp_w(iWidthReq);
      pend_vld_d = 1'b1;
    end

    if (take_hold) begin
      if (!hold_vld_q) begin
        hold_d     = iAdcData;
        hold_vld_d = 1'b1;
      end else begin
        overrun_d = 1'b1;
      end
    end

    unique case (state_q)
      S_FLUSH: begin
        if (flush_cnt_q == FLUSH_LAST) begin
          filt_width_d = active_w_q;
          prime_cnt_d  = '0;
          state_d      = S_IDLE;
        end else begin
          flush_cnt_d = flush_cnt_q + 1'b1;
        end
      end
      S_IDLE: begin
        if (wpend) begin
          active_w_d   = iWidthLoad ?
                         clamp_w(iWidthReq) :
                         pend_w_q;
          pend_vld_d   = 1'b0;
          filt_width_d = '0;
          flush_cnt_d  = '0;
          state_d      = S_FLUSH;
        end else if (hold_vld_q) begin
          filt_data_d = hold_q;
          filt_req_d  = 1'b1;
          state_d     = S_REQ;
          // A fresh strobe refills the slot just vacated.
          if (iAdcValid) begin
            hold_d = iAdcData;
          end else begin
            hold_vld_d = 1'b0;
          end
        end else if (iAdcValid) begin
          filt_data_d = iAdcData;
          filt_req_d  = 1'b1;
          state_d     = S_REQ;
        end
      end
      S_REQ: begin
        to_cnt_d = '0;
        state_d  = S_WAIT_ACK;
      end
      S_WAIT_ACK: begin
        if (iFiltReady) begin
          data_d     = iFiltData;
          filt_req_d = 1'b0;
          state_d    = S_WAIT_LOW;
          if (primed_now) begin
            data_vld_d = 1'b1;
          end else begin
            prime_cnt_d = prime_cnt_q + 1'b1;
          end
        end else if (to_cnt_q == TO_LAST) begin
          timeout_d    = 1'b1;
          filt_req_d   = 1'b0;
          filt_width_d = '0;
          flush_cnt_d  = '0;
          state_d      = S_FLUSH;
        end else begin
          to_cnt_d = to_cnt_q + 1'b1;
        end
      end
      S_WAIT_LOW: begin
        if (!iFiltReady) begin
          state_d = S_IDLE;
        end
      end
      default: begin
        state_d = S_FLUSH;
      end
    endcase

    primed_d = (state_d != S_FLUSH) &&
               ((prime_cnt_d >= active_w_d) ||
                (active_w_d <= 12'd1));
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= S_FLUSH;
      flush_cnt_q  <= '0;
      to_cnt_q     <= '0;
      active_w_q   <= '0;
      pend_w_q     <= '0;
      pend_vld_q   <= 1'b0;
      hold_q       <= '0;
      hold_vld_q   <= 1'b0;
      prime_cnt_q  <= '0;
      primed_q     <= 1'b0;
      filt_data_q  <= '0;
      filt_req_q   <= 1'b0;
      filt_width_q <= '0;
      data_q       <= '0;
      data_vld_q   <= 1'b0;
      overrun_q    <= 1'b0;
      timeout_q    <= 1'b0;
    end else begin
      state_q      <= state_d;
      flush_cnt_q  <= flush_cnt_d;
      to_cnt_q     <= to_cnt_d;
      active_w_q   <= active_w_d;
      pend_w_q     <= pend_w_d;
      pend_vld_q   <= pend_vld_d;
      hold_q       <= hold_d;
      hold_vld_q   <= hold_vld_d;
      prime_cnt_q  <= prime_cnt_d;
      primed_q     <= primed_d;
      filt_data_q  <= filt_data_d;
      filt_req_q   <= filt_req_d;
      filt_width_q <= filt_width_d;
      data_q       <= data_d;
      data_vld_q   <= data_vld_d;
      overrun_q    <= overrun_d;
      timeout_q    <= timeout_d;
    end
  end

  assign oFiltData        = filt_data_q;
  assign oFiltSampleReady = filt_req_q;
  assign oFiltWidth       = filt_width_q;
  assign oData            = data_q;
  assign oDataValid       = data_vld_q;
  assign oPrimed          = primed_q;
  assign oOverrun         = overrun_q;
  assign oTimeout         = timeout_q;

endmodule

// File: tb/tb_moving_average_ctrl.sv
// tb_moving_average_ctrl: directed scenarios with a behavioural filter;
// expected oData values are queued and checked by a separate monitor.
`timescale 1ns/1ps
module tb_moving_average_ctrl;

  localparam int DW = 12;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic [DW-1:0] iAdcData;
  logic          iAdcValid;
  logic [11:0]   iWidthReq;
  logic          iWidthLoad;
  logic [DW-1:0] oFiltData;
  logic          oFiltSampleReady;
  logic [11:0]   oFiltWidth;
  logic [DW-1:0] iFiltData;
  logic          iFiltReady;
  logic [DW-1:0] oData;
  logic          oDataValid;
  logic          oPrimed;
  logic          oOverrun;
  logic          oTimeout;

  moving_average_ctrl dut (
    .clk              (clk),
    .rst              (rst),
    .iAdcData         (iAdcData),
    .iAdcValid        (iAdcValid),
    .iWidthReq        (iWidthReq),
    .iWidthLoad       (iWidthLoad),
    .oFiltData        (oFiltData),
    .oFiltSampleReady (oFiltSampleReady),
    .oFiltWidth       (oFiltWidth),
    .iFiltData        (iFiltData),
    .iFiltReady       (iFiltReady),
    .oData            (oData),
    .oDataValid       (oDataValid),
    .oPrimed          (oPrimed),
    .oOverrun         (oOverrun),
    .oTimeout         (oTimeout)
  );

  always #5 clk = ~clk;

  int n_pass  = 0;
  int n_total = 0;
  int exp_q[$];
  bit never_ack = 1'b0;

  task automatic check(input string name, input int act, input int exp);
    n_total++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d (0x%0h) want %0d (0x%0h)",
                  name, act, act, exp, exp);
  endtask

  // Scoreboard monitor
  int sb_exp;
  always @(negedge clk) begin
    if (!rst && oDataValid) begin
      if (exp_q.size() == 0) begin
        n_total++;
        $display("FAIL unexpected_valid: got oData=0x%0h want no strobe",
                 oData);
      end else begin
        sb_exp = exp_q.pop_front();
        check("odata", int'(oData), sb_exp);
      end
    end
  end

  // Behavioural movingAverage filter
  int hist[$];
  int dly;
  int fw;
  int fsum;
  initial begin
    iFiltReady = 1'b0;
    iFiltData  = '0;
    dly        = 0;
    forever begin
      @(posedge clk); #1;
      if (rst) begin
        iFiltReady = 1'b0;
        dly = 0;
        hist.delete();
      end else begin
        if (oFiltWidth == 12'd0) hist.delete();
        if (iFiltReady) begin
          if (!oFiltSampleReady) iFiltReady = 1'b0;
        end else if (oFiltSampleReady && !never_ack) begin
          if (dly < 2) begin
            dly++;
          end else begin
            dly = 0;
            fw = int'(oFiltWidth);
            hist.push_back(int'(oFiltData));
            while (hist.size() > ((fw < 1) ? 1 : fw))
              void'(hist.pop_front());
            if (fw <= 1) begin
              iFiltData = oFiltData;
            end else begin
              fsum = 0;
              foreach (hist[i]) fsum += hist[i];
              iFiltData = DW'(fsum / hist.size());
            end
            iFiltReady = 1'b1;
          end
        end
      end
    end
  end

  task automatic strobe(input logic [DW-1:0] d, input bit v,
                        input logic [11:0] w, input bit l);
    @(posedge clk); #1;
    iAdcData   = d;
    iAdcValid  = v;
    iWidthReq  = w;
    iWidthLoad = l;
    @(posedge clk); #1;
    iAdcValid  = 1'b0;
    iWidthLoad = 1'b0;
  endtask

  task automatic settle();
    repeat (8) @(posedge clk);
    @(negedge clk);
  endtask

  task automatic check_reset(input string t);
    check({t, "_fwidth"}, int'(oFiltWidth), 0);
    check({t, "_freq"}, int'(oFiltSampleReady), 0);
    check({t, "_fdata"}, int'(oFiltData), 0);
    check({t, "_odata"}, int'(oData), 0);
    check({t, "_ovalid"}, int'(oDataValid), 0);
    check({t, "_primed"}, int'(oPrimed), 0);
    check({t, "_overrun"}, int'(oOverrun), 0);
    check({t, "_timeout"}, int'(oTimeout), 0);
  endtask

  int n;

  initial begin
    iAdcData   = '0;
    iAdcValid  = 1'b0;
    iWidthReq  = '0;
    iWidthLoad = 1'b0;

    // 1: reset, width 4, six samples
    repeat (3) @(posedge clk);
    @(negedge clk);
    check_reset("rst");
    rst = 1'b0;
    settle();
    strobe('0, 1'b0, 12'd4, 1'b1);
    settle();
    check("t1_width", int'(oFiltWidth), 4);
    check("t1_primed0", int'(oPrimed), 0);
    for (int i = 1; i <= 6; i++) begin
      if (i == 5) exp_q.push_back(350);
      if (i == 6) exp_q.push_back(450);
      strobe(DW'(i * 100), 1'b1, '0, 1'b0);
      repeat (38) @(posedge clk);
      @(negedge clk);
      if (i == 3) check("t1_primed_3", int'(oPrimed), 0);
      if (i == 4) check("t1_primed_4", int'(oPrimed), 1);
    end

    // 2: width 1 bypass, handshake shape
    strobe('0, 1'b0, 12'd1, 1'b1);
    settle();
    check("t2_width", int'(oFiltWidth), 1);
    check("t2_primed", int'(oPrimed), 1);
    exp_q.push_back(12'hABC);
    strobe(12'hABC, 1'b1, '0, 1'b0);
    @(negedge clk);
    check("t2_req_rise", int'(oFiltSampleReady), 1);
    n = 0;
    while (!iFiltReady && n < 20) begin
      @(negedge clk);
      n++;
    end
    check("t2_ack_seen", int'(iFiltReady), 1);
    check("t2_req_held", int'(oFiltSampleReady), 1);
    @(negedge clk);
    check("t2_req_drop", int'(oFiltSampleReady), 0);
    repeat (10) @(posedge clk);

    // 3: clamp and width-0 bypass
    strobe('0, 1'b0, 12'hFFF, 1'b1);
    @(negedge clk);
    check("t3_flush_zero", int'(oFiltWidth), 0);
    settle();
    check("t3_clamp_max", int'(oFiltWidth), 2048);
    check("t3_primed_big", int'(oPrimed), 0);
    strobe('0, 1'b0, 12'd2049, 1'b1);
    settle();
    check("t3_clamp_2049", int'(oFiltWidth), 2048);
    strobe('0, 1'b0, 12'd0, 1'b1);
    settle();
    check("t3_width0", int'(oFiltWidth), 0);
    check("t3_primed0w", int'(oPrimed), 1);
    exp_q.push_back(12'h321);
    strobe(12'h321, 1'b1, '0, 1'b0);
    repeat (15) @(posedge clk);

    // 4: three back-to-back strobes
    @(negedge clk);
    check("t4_overrun0", int'(oOverrun), 0);
    exp_q.push_back(12'h111);
    exp_q.push_back(12'h222);
    @(posedge clk); #1;
    iAdcValid = 1'b1;
    iAdcData  = 12'h111;
    @(posedge clk); #1;
    iAdcData  = 12'h222;
    @(posedge clk); #1;
    iAdcData  = 12'h333;
    @(posedge clk); #1;
    iAdcValid = 1'b0;
    repeat (30) @(posedge clk);
    @(negedge clk);
    check("t4_overrun1", int'(oOverrun), 1);
    check("t4_second_sent", int'(oFiltData), 12'h222);

    // 5: filter hang
    strobe('0, 1'b0, 12'd1, 1'b1);
    settle();
    check("t5_width", int'(oFiltWidth), 1);
    never_ack = 1'b1;
    strobe(12'h055, 1'b1, '0, 1'b0);
    n = 0;
    while (!oTimeout && n < 9000) begin
      @(negedge clk);
      n++;
    end
    check("t5_timeout_cyc", n, 8193);
    check("t5_req_drop", int'(oFiltSampleReady), 0);
    n = 0;
    while (oFiltWidth == 12'd0 && n < 20) begin
      n++;
      @(negedge clk);
    end
    check("t5_flush_len", n, 4);
    check("t5_width_back", int'(oFiltWidth), 1);
    never_ack = 1'b0;
    exp_q.push_back(12'h0AB);
    strobe(12'h0AB, 1'b1, '0, 1'b0);
    repeat (15) @(posedge clk);
    @(negedge clk);
    check("t5_sticky", int'(oTimeout), 1);

    // 6: load + sample same cycle, then rst in WAIT_ACK
    never_ack = 1'b1;
    strobe(12'h0CC, 1'b1, 12'd2, 1'b1);
    n = 0;
    while (!oFiltSampleReady && n < 20) begin
      @(negedge clk);
      n++;
    end
    check("t6_req", int'(oFiltSampleReady), 1);
    check("t6_width", int'(oFiltWidth), 2);
    check("t6_fdata", int'(oFiltData), 12'h0CC);
    repeat (3) @(posedge clk);
    #1 rst = 1'b1;
    @(posedge clk);
    @(negedge clk);
    check_reset("t6");
    rst = 1'b0;
    never_ack = 1'b0;
    exp_q.push_back(12'h0DD);
    strobe(12'h0DD, 1'b1, '0, 1'b0);
    repeat (20) @(posedge clk);
    @(negedge clk);
    check("t6_primed_after", int'(oPrimed), 1);

    check("sb_drain", exp_q.size(), 0);
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
